// File: rtl/sram_ahb_arb_if.sv
// AHB-Lite master bus between sram_ahb_arb and the SRAM controller slave port.
//   master modport : arbiter side (drives address/control/write data and hready,
//                    receives hready_resp/hresp/hrdata from the slave)
//   slave  modport : SRAM controller side
interface sram_ahb_arb_if;
    logic        hsel;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, hwrite, htrans, hsize, hburst, haddr, hwdata, hready,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hsel, hwrite, htrans, hsize, hburst, haddr, hwdata, hready,
        output hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/sram_ahb_arb.sv
// Two-port round-robin arbiter and AHB-Lite SINGLE-transfer sequencer in front
// of the SRAM controller slave port. One transfer outstanding at a time.
//
// Ports:
//   hclk, hresetn            clock, async active-low reset
//   req/we/size/addr/wdata   per-requester request (0 and 1), held until ack
//   ack/err/rdata            per-requester completion pulse, status, read data
//   test_mode                BIST/DFT ownership of the SRAM
//   ahb                      AHB master bus (sram_ahb_arb_if.master)
//
// Optional feature macro: SRAM_ARB_TEST_LOCK_EN
//   defined   : requests arriving in IDLE while test_mode=1 are rejected with err
//   undefined : test_mode is ignored
//
// state | meaning
// IDLE  | arbitrate, latch winner, check legality
// ADDR  | AHB address phase (NONSEQ SINGLE)
// DATA  | AHB data phase, wait for hready_resp
// RESP  | one-cycle ack pulse to the granted port
module sram_ahb_arb #(
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    input  logic        test_mode,
    sram_ahb_arb_if.master ahb
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state;
    logic        last_gnt;
    logic        gnt;
    logic        lat_we;
    logic [31:0] lat_wdata;

    logic        win;
    logic        win_we;
    logic [1:0]  win_size;
    logic [14:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_bad;
    logic        lock;
    logic        unused_cfg;

    // The timeout limit has no user in this build; fold it away with test_mode.
    assign unused_cfg = test_mode ^ (TO_CYCLES == 0);

    assign ahb.hready = ahb.hready_resp;

    always_comb begin
        // On a tie, the port that did not win last time takes the grant.
        win       = req1 & (~req0 | ~last_gnt);
        win_we    = win ? we1    : we0;
        win_size  = win ? size1  : size0;
        win_addr  = win ? addr1  : addr0;
        win_wdata = win ? wdata1 : wdata0;
        win_bad   = (win_size == 2'd3)
                  | ((win_size == 2'd1) & win_addr[0])
                  | ((win_size == 2'd2) & (win_addr[1:0] != 2'b00));
`ifdef SRAM_ARB_TEST_LOCK_EN
        lock      = test_mode;
`else
        lock      = 1'b0;
`endif
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= 32'h0;
            ahb.hsel   <= 1'b0;
            ahb.htrans <= 2'b00;
            ahb.hwrite <= 1'b0;
            ahb.hsize  <= 3'b000;
            ahb.hburst <= 3'b000;
            ahb.haddr  <= 32'h0;
            ahb.hwdata <= 32'h0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 32'h0;
            rdata1     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt       <= win;
                        last_gnt  <= win;
                        lat_we    <= win_we;
                        lat_wdata <= win_wdata;
                        if (win_bad | lock) begin
                            // Rejected without touching the bus.
                            state <= RESP;
                            if (win) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            state      <= ADDR;
                            ahb.hsel   <= 1'b1;
                            ahb.htrans <= 2'b10;
                            ahb.hburst <= 3'b000;
                            ahb.hsize  <= {1'b0, win_size};
                            ahb.haddr  <= {17'b0, win_addr};
                            ahb.hwrite <= win_we;
                        end
                    end
                end
                ADDR: begin
                    ahb.hsel   <= 1'b0;
                    ahb.htrans <= 2'b00;
                    ahb.hwdata <= lat_wdata;
                    state      <= DATA;
                end
                DATA: begin
                    if (ahb.hready_resp) begin
                        state <= RESP;
                        if (gnt) begin
                            ack1 <= 1'b1;
                            err1 <= (ahb.hresp != 2'b00);
                            if (!lat_we) rdata1 <= ahb.hrdata;
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= (ahb.hresp != 2'b00);
                            if (!lat_we) rdata0 <= ahb.hrdata;
                        end
                    end
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
